// File: rtl/armaria_io_pkg.sv
// Shared constants for the board I/O path (switch capture and display driver).
package armaria_io_pkg;
    localparam int SW_WIDTH                = 16;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int DEBOUNCE_DEPTH          = 3;
    localparam int ARM_TICKS               = 3;
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch input: synchroniser, tick-loaded sample history and the debounced bit.
// rise/fall pulse in the same cycle the stable bit is about to change.
module sw_debounce_bit
    import armaria_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0]    sync;
    logic [DEBOUNCE_DEPTH-2:0] hist;
    logic                      sample;
    logic                      agree;
    logic                      change;

    assign sample = sync[SYNC_STAGES-1];
    // The incoming sample plus the older history entries form the full debounce window.
    assign agree  = (hist == {(DEBOUNCE_DEPTH-1){sample}});
    assign change = tick && agree && (sample != stable);
    assign rise   = change && sample;
    assign fall   = change && !sample;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync   <= '0;
            hist   <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (tick) begin
                hist <= {hist[DEBOUNCE_DEPTH-3:0], sample};
                if (change) begin
                    stable <= sample;
                end
            end
        end
    end

endmodule

// File: rtl/sw_input_capture.sv
// Switch capture: shared debounce prescaler, power-up arming and sticky edge flags with ack clear.
// Define SW_FALLING_EDGE_EN to also flag 1->0 transitions of the stable word.
module sw_input_capture
    import armaria_io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_sw,
    input  logic             ack,
    output logic [WIDTH-1:0] stable_sw,
    output logic [WIDTH-1:0] edge_flags,
    output logic             irq,
    output logic             tick
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW = (ARM_TICKS > 1) ? $clog2(ARM_TICKS) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_TICKS - 1);
`ifdef SW_FALLING_EDGE_EN
    localparam logic FALL_EN = 1'b1;
`else
    localparam logic FALL_EN = 1'b0;
`endif

    logic [CW-1:0]    count;
    logic [AW-1:0]    arm_cnt;
    logic             armed;
    logic [WIDTH-1:0] rise_v;
    logic [WIDTH-1:0] fall_v;
    logic [WIDTH-1:0] flag_set;
    logic [WIDTH-1:0] flag_next;

    assign tick = (count == COUNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // armed goes high on the ARM_TICKS-th tick; that tick's own updates are still unflagged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (tick && !armed) begin
            if (arm_cnt == ARM_LAST) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_bit (
            .clock (clock),
            .reset (reset),
            .raw   (raw_sw[i]),
            .tick  (tick),
            .stable(stable_sw[i]),
            .rise  (rise_v[i]),
            .fall  (fall_v[i])
        );
    end

    always_comb begin
        flag_set = '0;
        if (armed) begin
            flag_set = rise_v | (FALL_EN ? fall_v : '0);
        end
        // New events override a same-cycle acknowledge.
        flag_next = (ack ? '0 : edge_flags) | flag_set;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_flags <= '0;
        end else begin
            edge_flags <= flag_next;
        end
    end

    assign irq = |edge_flags;

endmodule

// File: doc/sw_input_capture.md
# sw_input_capture

Input-side counterpart of the board I/O path: takes the 16 raw slide switches, synchronises and debounces them, and presents a stable switch word plus sticky per-bit edge flags that the processor can poll or take as a request. The processor clears the flags with an acknowledge handshake. The block sits between the board pins and the external-memory `sw` input. It is the reading end, where the display/LED driver is the writing end.

## Interface
- `WIDTH`, 16: number of switch inputs.
- `DEBOUNCE_CYCLES`, 50000: clock cycles between debounce samples; ≥1 (1 ms at 50 MHz).
- `SYNC_STAGES`, 2: synchroniser flip-flops per input; ≥2.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `raw_sw`  in  WIDTH  asynchronous switch pins.
- `ack`  in  1  processor acknowledge; a one-cycle pulse clears the flags.
- `stable_sw`  out  WIDTH  debounced switch word, feeds EM `sw`.
- `edge_flags`  out  WIDTH  sticky per-bit change flags.
- `irq`  out  1  OR of `edge_flags`.
- `tick`  out  1  one-cycle sample strobe, for debug and test.

## Operation
- Reset (asserted low) forces all outputs and internal state to 0: prescaler, synchronisers, sample history, `stable_sw`, `edge_flags`, `irq`, `tick`, and `armed`.
- Prescaler:
  - Counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
  - `tick`=1 in the cycle when count==DEBOUNCE_CYCLES-1.
  - If DEBOUNCE_CYCLES=1, `tick` stays high on every cycle.
- Each bit passes through SYNC_STAGES flip-flops, then a 3-deep sample shift register that is loaded only on `tick`.
- Stable update: on a tick, if the new sample and the 2 previous samples agree and differ from `stable_sw[i]`, then `stable_sw[i]` takes that value at that clock edge. Otherwise `stable_sw[i]` holds. Glitches shorter than 3 ticks never reach `stable_sw`.
- Arming:
  - `armed` sets on the 3rd tick after reset release.
  - Stable updates happen even while `armed`=0.
  - Flags are not set while `armed`=0, so switches that are already on at power-up do not raise `irq`.
- Edge flag: `edge_flags[i]` sets at the same edge where `stable_sw[i]` rises 0→1, provided `armed`=1. Falling edges: see Configuration.
- Ack handshake:
  - `ack`=1 clears every flag whose bit has no set event in that same cycle.
  - When set and clear hit the same bit in the same cycle, set wins.
  - A bit that is already set and gets another event stays set. No counting.
- `irq` is combinational OR of the `edge_flags` register.

## Timing
- Latency from a `raw_sw` change to a `stable_sw` change is synchroniser delay plus 2 to 3 tick periods.
  - Minimum: SYNC_STAGES + 2·DEBOUNCE_CYCLES + 1 cycles.
  - Maximum: SYNC_STAGES + 3·DEBOUNCE_CYCLES cycles.
- `edge_flags` and `irq` change in the same cycle as `stable_sw`.
- `ack` takes effect at the next clock edge. `irq` falls the cycle after `ack` when no new event arrives.
- If `ack` is held high for several cycles, flags are cleared on each of those cycles. Set still has priority over clear.
- Reset asserted mid-debounce drops the pending transition. After release, the arming rule applies again.

## Configuration
- `SW_FALLING_EDGE_EN`:
  - Defined: `edge_flags[i]` also sets on a 1→0 transition of `stable_sw[i]`.
  - Undefined: only 0→1 transitions set flags. Falling transitions update `stable_sw` only.
- Either way, the ports and latency are identical.

## Structure
- Shared package `armaria_io_pkg` holds:
  - `SW_WIDTH`=16
  - default `DEBOUNCE_CYCLES`
  - `DEBOUNCE_DEPTH`=3
  - `ARM_TICKS`=3
- The prescaler, `armed` logic and flag register live in the top. The prescaler is shared by all bits.
- Sub-module `sw_debounce_bit`, one instance per bit: synchroniser, 3-sample history, and stable bit. It outputs `stable` and a one-cycle `rise`/`fall` pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
- Reset release with `raw_sw`=16'h0001:
  - `stable_sw`=16'h0001 within 14 cycles.
  - `edge_flags`=0 and `irq`=0 throughout, because the block is not yet armed.
- After arming, drive `raw_sw[3]` 0→1 and hold:
  - `stable_sw[3]`=1 between 11 and 14 cycles after the change.
  - `edge_flags`=16'h0008 and `irq`=1 in that same cycle.
- Glitch on `raw_sw[5]` high for 6 cycles, then low: `stable_sw[5]` stays 0 and `edge_flags[5]` stays 0.
- With flag 3 set, pulse `ack` for 1 cycle: `edge_flags`=0 and `irq`=0 on the next cycle.
- Pulse `ack` in the exact cycle `stable_sw[7]` rises: `edge_flags[7]`=1 afterward, while earlier flags clear.
- Build with `SW_FALLING_EDGE_EN`, release `raw_sw[3]` 1→0: `edge_flags[3]` sets. Without the macro, it stays 0.
